// File: rtl/sequencer_pkg.sv
// Shared types and widths for the state sequencer and the downstream register stage.
package sequencer_pkg;
  localparam int SEQ_STATE_W = 4;
  localparam int SEQ_DWELL_W = 8;
  localparam int IDLE_STATE  = 0;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} phase_e;
endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter for per-state dwell; dwell=0 loads as a one-cycle dwell.
module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               zero_o
);
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - DWELL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/state_sequencer.sv
// Walks current_state through 1..LAST_STATE with a programmable dwell per state,
// with hold/resume, abort and direct load; all outputs registered.
module state_sequencer
  import sequencer_pkg::*;
#(
  parameter int STATE_W    = SEQ_STATE_W,
  parameter int DWELL_W    = SEQ_DWELL_W,
  parameter int LAST_STATE = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  input  logic               abort,
  input  logic               load_en,
  input  logic [STATE_W-1:0] load_val,
  input  logic [DWELL_W-1:0] dwell,
  output logic [STATE_W-1:0] current_state,
  output logic               busy,
  output logic               step_pulse,
  output logic               done
);
  localparam logic [STATE_W-1:0] LAST_S = STATE_W'(LAST_STATE);
  localparam logic [STATE_W-1:0] IDLE_S = STATE_W'(IDLE_STATE);

  phase_e             phase_q;
  logic [STATE_W-1:0] state_q;
  logic               busy_q, step_q, done_q;

  logic [STATE_W-1:0] load_sat;
  logic               active, pause_load, counting, cnt_zero;
  logic               cnt_load, cnt_en;

  assign load_sat   = (load_val > LAST_S) ? LAST_S : load_val;
  assign active     = (phase_q == RUN) || (phase_q == PAUSE);
  assign pause_load = (phase_q == PAUSE) && load_en;
  // A resume edge counts like a normal RUN edge, so a pause costs exactly the hold cycles.
  assign counting   = active && !abort && !pause_load && !hold;
  assign cnt_en     = counting && !cnt_zero;
  assign cnt_load   = !abort && (((phase_q == IDLE) && (load_en || start)) || pause_load ||
                                 (counting && cnt_zero && state_q < LAST_S));

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (abort),
    .load_i  (cnt_load),
    .en_i    (cnt_en),
    .dwell_i (dwell),
    .zero_o  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= IDLE;
      state_q <= IDLE_S;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        phase_q <= IDLE;
        state_q <= IDLE_S;
        busy_q  <= 1'b0;
      end else begin
        case (phase_q)
          IDLE: begin
            if (load_en) begin
              phase_q <= RUN;
              state_q <= (load_sat == IDLE_S) ? STATE_W'(1) : load_sat;
              busy_q  <= 1'b1;
            end else if (start) begin
              phase_q <= RUN;
              state_q <= STATE_W'(1);
              busy_q  <= 1'b1;
            end
          end
          RUN, PAUSE: begin
            if (pause_load) begin
              state_q <= load_sat;
            end else if (hold) begin
              phase_q <= PAUSE;
            end else if (!cnt_zero) begin
              phase_q <= RUN;
            end else if (state_q < LAST_S) begin
              phase_q <= RUN;
              state_q <= state_q + STATE_W'(1);
              step_q  <= 1'b1;
            end else begin
              phase_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          DONE: begin
            phase_q <= IDLE;
            state_q <= IDLE_S;
          end
          default: phase_q <= IDLE;
        endcase
      end
    end
  end

  assign current_state = state_q;
  assign busy          = busy_q;
  assign step_pulse    = step_q;
  assign done          = done_q;
endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: a remaining-cycles model checked every cycle,
// plus literal expectations on run shape for each scenario.
module tb_state_sequencer;
  localparam int LAST = 9;
  localparam int P_IDLE = 0, P_RUN = 1, P_PAUSE = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       reset, start, hold, abort, load_en;
  logic [3:0] load_val;
  logic [7:0] dwell;
  logic [3:0] current_state;
  logic       busy, step_pulse, done;

  int checks = 0, failures = 0;
  bit cmp_en = 1'b0;

  state_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .abort(abort),
    .load_en(load_en), .load_val(load_val), .dwell(dwell),
    .current_state(current_state), .busy(busy), .step_pulse(step_pulse), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model tracks how many cycles remain in the current state rather than a counter value.
  int m_ph = P_IDLE, m_st = 0, m_left = 0;
  bit m_step = 1'b0, m_done = 1'b0;

  always @(posedge clk) begin
    int d, lv;
    d  = (dwell == 8'd0) ? 1 : int'(dwell);
    lv = (int'(load_val) > LAST) ? LAST : int'(load_val);
    m_step = 1'b0;
    m_done = 1'b0;
    if (reset) begin
      m_ph = P_IDLE; m_st = 0; m_left = 0;
    end else if (abort) begin
      m_ph = P_IDLE; m_st = 0; m_left = 0;
    end else if (m_ph == P_IDLE) begin
      if (load_en) begin
        m_ph = P_RUN; m_st = (lv == 0) ? 1 : lv; m_left = d;
      end else if (start) begin
        m_ph = P_RUN; m_st = 1; m_left = d;
      end
    end else if (m_ph == P_PAUSE && load_en) begin
      m_st = lv; m_left = d;
    end else if (m_ph == P_RUN || m_ph == P_PAUSE) begin
      if (hold) m_ph = P_PAUSE;
      else begin
        m_ph = P_RUN;
        m_left--;
        if (m_left == 0) begin
          if (m_st < LAST) begin
            m_st++; m_left = d; m_step = 1'b1;
          end else begin
            m_ph = P_DONE; m_done = 1'b1;
          end
        end
      end
    end else begin
      m_ph = P_IDLE; m_st = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_state", int'(current_state), m_st);
      chk("model_busy",  int'(busy), int'(m_ph == P_RUN || m_ph == P_PAUSE));
      chk("model_step",  int'(step_pulse), int'(m_step));
      chk("model_done",  int'(done), int'(m_done));
    end
  end

  int seq[$];
  int n_busy, n_step, n_done, done_idx, st3_cnt, hold_steps, first_state;
  int pre_state, pre_busy, pre_done, post_state, post_busy;

  // Samples ncyc cycles; pulse inputs drop after each sample, events fire after sample index i.
  task automatic observe(input int ncyc, input int h_on = -1, input int h_off = -1,
                         input int ab = -1, input int ld = -1, input int ldv = 0,
                         input int rs = -1);
    int ev;
    ev = (ab >= 0) ? ab : rs;
    seq.delete();
    n_busy = 0; n_step = 0; n_done = 0; done_idx = -1; st3_cnt = 0; hold_steps = 0;
    first_state = -1; pre_state = -1; pre_busy = -1; pre_done = -1;
    post_state = -1; post_busy = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i == 0) first_state = int'(current_state);
      if (busy) begin
        n_busy++;
        seq.push_back(int'(current_state));
        if (current_state == 4'd3) st3_cnt++;
      end
      if (step_pulse) begin
        n_step++;
        if (h_on >= 0 && i > h_on && (h_off < 0 || i <= h_off)) hold_steps++;
      end
      if (done) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
      end
      if (ev >= 0 && i == ev) begin
        pre_state = int'(current_state); pre_busy = int'(busy); pre_done = int'(done);
      end
      if (ev >= 0 && i == ev + 1) begin
        post_state = int'(current_state); post_busy = int'(busy);
      end
      start = 1'b0; load_en = 1'b0; abort = 1'b0; reset = 1'b0;
      if (i == h_on)  hold = 1'b1;
      if (i == h_off) hold = 1'b0;
      if (i == ab)    abort = 1'b1;
      if (i == ld) begin load_en = 1'b1; load_val = 4'(ldv); end
      if (i == rs)    reset = 1'b1;
    end
    hold = 1'b0;
  endtask

  function automatic int seq_bad_d2();
    int bad = 0;
    foreach (seq[i]) if (seq[i] != i / 2 + 1) bad++;
    return bad;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
    load_en = 1'b0; load_val = 4'd0; dwell = 8'd2;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_state", int'(current_state), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_step",  int'(step_pulse), 0);
    chk("rst_done",  int'(done), 0);
    reset = 1'b0;

    dwell = 8'd2; start = 1'b1; observe(24);
    chk("d2_busy_cycles", n_busy, 18);
    chk("d2_steps", n_step, 8);
    chk("d2_dones", n_done, 1);
    chk("d2_done_idx", done_idx, 18);
    chk("d2_seq_bad", seq_bad_d2(), 0);
    chk("d2_end_state", int'(current_state), 0);

    dwell = 8'd0; start = 1'b1; observe(14);
    chk("d0_busy_cycles", n_busy, 9);
    chk("d0_steps", n_step, 8);
    chk("d0_dones", n_done, 1);

    dwell = 8'd4; start = 1'b1; observe(50, 9, 14);
    chk("hold_st3_cycles", st3_cnt, 9);
    chk("hold_steps_paused", hold_steps, 0);
    chk("hold_busy_cycles", n_busy, 41);
    chk("hold_dones", n_done, 1);

    dwell = 8'd2; start = 1'b1; observe(20, -1, -1, 10);
    chk("ab6_pre_state", pre_state, 6);
    chk("ab6_post_state", post_state, 0);
    chk("ab6_post_busy", post_busy, 0);
    chk("ab6_dones", n_done, 0);

    dwell = 8'd2; start = 1'b1; observe(20, 3, -1, 6);
    chk("abp_pre_busy", pre_busy, 1);
    chk("abp_post_state", post_state, 0);
    chk("abp_post_busy", post_busy, 0);
    chk("abp_dones", n_done, 0);

    dwell = 8'd0; start = 1'b1; observe(15, -1, -1, 9);
    chk("abd_pre_done", pre_done, 1);
    chk("abd_post_state", post_state, 0);
    chk("abd_post_busy", post_busy, 0);
    chk("abd_dones", n_done, 1);

    dwell = 8'd1; load_val = 4'd12; load_en = 1'b1; observe(6);
    chk("ld12_first", first_state, 9);
    chk("ld12_busy_cycles", n_busy, 1);
    chk("ld12_dones", n_done, 1);

    load_val = 4'd0; load_en = 1'b1; observe(14);
    chk("ld0_first", first_state, 1);
    chk("ld0_busy_cycles", n_busy, 9);
    chk("ld0_dones", n_done, 1);

    dwell = 8'd2; start = 1'b1; observe(24, -1, -1, -1, 2, 7);
    chk("ldrun_busy_cycles", n_busy, 18);
    chk("ldrun_steps", n_step, 8);
    chk("ldrun_seq_bad", seq_bad_d2(), 0);

    dwell = 8'd3; start = 1'b1; observe(40, 1, 5, -1, 3, 5);
    chk("ldpause_dones", n_done, 1);
    chk("ldpause_steps", n_step, 4);

    dwell = 8'd2; start = 1'b1; observe(20, -1, -1, -1, -1, 0, 8);
    chk("rst5_pre_state", pre_state, 5);
    chk("rst5_post_state", post_state, 0);
    chk("rst5_post_busy", post_busy, 0);
    chk("rst5_dones", n_done, 0);
    start = 1'b1; observe(4);
    chk("rst5_restart", first_state, 1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
